// File: rtl/result_unloader.sv
// Result-region read-out engine: walks SRAM A/B port 1 over an address range
// and streams {A,B} words through a 2-entry FIFO on a valid/ready interface.
module result_unloader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   start_addr_i,
  input  logic [ADDR_W-1:0]   end_addr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                csb_o,
  output logic [ADDR_W-1:0]   addr_o,
  input  logic [DATA_W-1:0]   rdata_a_i,
  input  logic [DATA_W-1:0]   rdata_b_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [2*DATA_W-1:0] m_data_o,
  output logic                m_last_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic              infl_q;
  logic              infl_last_q;

  logic [2*DATA_W:0] mem_q [2];
  logic              wr_q;
  logic              rd_q;
  logic [1:0]        cnt_q;

  logic       pop;
  logic       push;
  logic       rd_en;
  logic       last_rd;
  logic       head_last;
  logic [2:0] occ;

  assign pop       = (cnt_q != 2'd0) && m_ready_i;
  assign push      = infl_q;
  assign last_rd   = (rem_q == '0);
  assign head_last = mem_q[rd_q][2*DATA_W];

  // Credit counts buffered words plus the read in flight, net of this pop.
  assign occ   = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
  assign rd_en = (state_q == ISSUE) && (occ < 3'd2);

  assign csb_o     = ~rd_en;
  assign addr_o    = rd_en ? ptr_q : addr_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = mem_q[rd_q][2*DATA_W-1:0];
  assign m_last_o  = head_last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = ISSUE;
      ISSUE: if (rd_en && last_rd) state_d = DRAIN;
      DRAIN: if (pop && head_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      infl_q      <= rd_en;
      infl_last_q <= rd_en && last_rd;
      if (state_q == IDLE && start_i) begin
        ptr_q <= start_addr_i;
        rem_q <= end_addr_i - start_addr_i;
      end else if (rd_en) begin
        addr_q <= ptr_q;
        ptr_q  <= ptr_q + ADDR_W'(1);
        rem_q  <= rem_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {infl_last_q, rdata_a_i, rdata_b_i};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader: SRAM model, table of ranges,
// scoreboard queue of expected beats, plus reset corner sequences.
module tb_result_unloader;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          busy_o, done_o, csb_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] ra = '0, rb = '0;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [2*DW-1:0] m_data;

  result_unloader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i),
    .start_addr_i(start_addr), .end_addr_i(end_addr),
    .busy_o(busy_o), .done_o(done_o), .csb_o(csb_o), .addr_o(addr_o),
    .rdata_a_i(ra), .rdata_b_i(rb),
    .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_last_o(m_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] mem_b [512];
  always @(posedge clk) if (!csb_o) begin
    ra <= mem_a[addr_o];
    rb <= mem_b[addr_o];
  end

  typedef struct {
    logic [2*DW-1:0] data;
    logic            last;
  } exp_t;

  typedef struct {
    logic [AW-1:0] st;
    logic [AW-1:0] en;
    int            mode;
    int            n;
    bit            restart;
  } rec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   s_cyc = 0;
  int   rmode = 0;
  int   beats = 0;
  int   first_rel = -1;
  int   issued = 0;
  int   popped = 0;
  logic [AW-1:0] exp_addr = '0;
  bit   stall_prev = 0;
  logic [2*DW-1:0] prev_data;
  logic prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = (cyc % 3 == 0);
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (!csb_o) begin
        chk("issue_addr", 64'(addr_o), 64'(exp_addr));
        exp_addr = exp_addr + 1'b1;
        issued++;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(m_data), 64'(0));
          n_bad += (m_data == 0) ? 1 : 0;
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last", 64'(m_last), 64'(e.last));
        end
        if (first_rel < 0) first_rel = cyc - s_cyc + 1;
        beats++;
        popped++;
      end
      chk("credit_limit", 64'(issued - popped <= 2), 64'd1);
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_csb", 64'(csb_o), 64'd1);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
  endtask

  task automatic pulse_start(input logic [AW-1:0] st, input logic [AW-1:0] en);
    @(posedge clk); #1;
    start_i = 1'b1; start_addr = st; end_addr = en;
    @(posedge clk); #1;
    start_i = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic run(input rec_t r);
    logic [AW-1:0] a;
    int rel;
    bit got;
    bit quiet;
    a = r.st;
    for (int i = 0; i < r.n; i++) begin
      exp_t e;
      e.data = {32'hA000_0000 + 32'(a), 32'(a)};
      e.last = (i == r.n - 1);
      sb.push_back(e);
      a = a + 1'b1;
    end
    rmode = r.mode; exp_addr = r.st;
    beats = 0; first_rel = -1; issued = 0; popped = 0;
    pulse_start(r.st, r.en);
    if (r.restart) begin
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
    end
    got = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done_o) begin got = 1; break; end
    end
    chk("done_seen", 64'(got), 64'd1);
    rel = cyc - s_cyc + 1;
    chk("beat_count", 64'(beats), 64'(r.n));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("busy_at_done", 64'(busy_o), 64'd1);
    if (r.mode == 0) begin
      chk("first_beat_cycle", 64'(first_rel), 64'd3);
      chk("done_cycle", 64'(rel), 64'(r.n + 3));
    end
    @(negedge clk);
    chk("busy_fall", 64'(busy_o), 64'd0);
    chk("done_pulse", 64'(done_o), 64'd0);
    quiet = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_valid || !csb_o || busy_o) quiet = 0;
    end
    chk("idle_quiet", 64'(quiet), 64'd1);
    sb.delete();
  endtask

  rec_t tbl [7];

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 32'hA000_0000 + i;
      mem_b[i] = i;
    end
    tbl[0] = '{9'h010, 9'h013, 0, 4, 1'b0};
    tbl[1] = '{9'h010, 9'h013, 1, 4, 1'b0};
    tbl[2] = '{9'h1FE, 9'h001, 0, 4, 1'b0};
    tbl[3] = '{9'h055, 9'h055, 0, 1, 1'b1};
    tbl[4] = '{9'h020, 9'h03F, 2, 32, 1'b0};
    tbl[5] = '{9'h100, 9'h0FF, 2, 512, 1'b0};
    tbl[6] = '{9'h1F0, 9'h00F, 0, 32, 1'b0};

    #3 rst_n = 1'b0;
    #1 chk_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Reset with one word buffered and one read in flight.
    rmode = 3; exp_addr = 9'h000; issued = 0; popped = 0;
    pulse_start(9'h000, 9'h009);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 chk_reset_vals();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    issued = 0; popped = 0;
    begin
      bit quiet = 1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (m_valid || !csb_o || busy_o) quiet = 0;
      end
      chk("post_reset_quiet", 64'(quiet), 64'd1);
    end
    run('{9'h1A0, 9'h1A3, 0, 4, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
